csr_trap_sequencer: RTL and testbench
=====================================

// Module: csr_trap_sequencer
// PURPOSE
//   Sequences all accesses to the machine-level CSR unit: CSR instructions, synchronous
//   exceptions, MRET, and external-interrupt entry. It accepts one request at a time from
//   the core over a valid/ready handshake and arbitrates it against a pending external
//   interrupt, with the interrupt taking priority.
//   It drives the CSR unit's op/addr/write_value for exactly one cycle, captures the
//   registered read_value/fault, and returns the result over a valid/ready response channel.
// PARAMETERS
//   IRQ_CAUSE  12'h01B  addr_exception for interrupt entry (bit4=interrupt, [3:0]=11 external)
//   NOP_OP     3'b010   idle op; CSR unit changes no architectural state (raises only its fault flag)
// PORTS
//   clk          in   1   clock; all state updates on the rising edge
//   reset_n      in   1   asynchronous, active-low reset
//   req_valid    in   1   core request valid
//   req_ready    out  1   request accepted when req_valid & req_ready
//   req_op       in   3   000 exc, 001 MRET, 101 RW, 110 RS, 111 RC (same encoding as csr_op)
//   req_addr     in   12  CSR address, or exception cause {bit4, code[3:0]}
//   req_wdata    in   32  CSR write data, or faulting PC for exc
//   rsp_valid    out  1   response valid; held until rsp_ready
//   rsp_ready    in   1   core accepts response
//   rsp_rdata    out  32  CSR old value / trap vector / mepc
//   rsp_fault    out  1   captured csr_fault
//   rsp_is_irq   out  1   response belongs to an interrupt entry, not a core request
//   irq_ext      in   1   level-sensitive external interrupt request
//   irq_pc       in   32  PC saved to mepc on interrupt entry
//   csr_op       out  3   to CSR unit op
//   csr_addr     out  12  to CSR unit addr_exception
//   csr_wdata    out  32  to CSR unit write_value
//   csr_rdata    in   32  from CSR unit read_value; valid one cycle after issue
//   csr_fault    in   1   from CSR unit fault; valid one cycle after issue
// BEHAVIOUR
//   Reset values (async, reset_n=0):
//     state=IDLE; rsp_valid=0; rsp_rdata=0; rsp_fault=0; rsp_is_irq=0.
//     csr_op=NOP_OP; csr_addr=0; csr_wdata=0; shadows mie=mpie=meie=0.
//   Reset mid-operation abandons any in-flight access; no response is produced for it.
//   FSM states: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
//   IDLE
//     - irq_take = irq_ext & mie & meie.
//     - req_ready = !irq_take (combinational). req_ready=0 in all other states.
//     - irq_take=1: latch {000, IRQ_CAUSE, irq_pc}, set is_irq=1, go ISSUE.
//       A concurrent core request is not accepted and waits.
//     - Else, on the request handshake: latch req_*, set is_irq=0, go ISSUE.
//   ISSUE (one cycle)
//     - csr_op/csr_addr/csr_wdata = latched values. csr_op=NOP_OP in every other state.
//     - Shadow updates at the end of ISSUE:
//       exc: mpie<=mie, mie<=0.
//       MRET: mie<=mpie.
//       RW/RS/RC to 12'h300: mie from bit 3, mpie from bit 7 (RW=set to bit, RS=OR, RC=AND~).
//       RW/RS/RC to 12'h304: meie from bit 11, same rule.
//       Any other op or address: no shadow change.
//   CAPTURE (one cycle)
//     - rsp_rdata<=csr_rdata, rsp_fault<=csr_fault, rsp_is_irq<=is_irq, rsp_valid<=1.
//     - Go RESP.
//   RESP
//     - rsp_* held stable while rsp_valid & !rsp_ready.
//     - On rsp_ready: rsp_valid<=0, go IDLE.
//   Latency: request accepted at cycle 0 -> csr_op driven in cycle 1 -> rsp_valid high
//     from cycle 3. With rsp_ready=1, the next accept is possible in cycle 4.
//   Illegal req_op (010/011/100): issued unchanged; the CSR unit faults and rsp_fault=1.
//   irq_ext is level-sensitive. After entry the shadow mie=0 blocks re-entry until MRET
//     or a write that sets MIE.
// TESTING
//   T1 RW 12'h305 wdata 32'h1000 -> cycle 3 rsp rdata 0, fault 0.
//      Then RS 12'h305 wdata 0 -> rdata 32'h1000.
//   T2 RW 12'h7C0 -> rsp_fault=1, rsp_rdata=0, shadows unchanged.
//   T3 RS 12'h300 wdata 8, RS 12'h304 wdata 32'h800, then irq_ext=1, irq_pc=32'h200,
//      req_valid=1 in the same cycle -> req_ready=0.
//      Next cycle csr_op=000, csr_addr=12'h01B, csr_wdata=32'h200.
//      rsp_is_irq=1, rdata=32'h1000. irq_ext held high -> no second entry.
//   T4 After T3, MRET -> rsp rdata 32'h200, shadow mie=1.
//      irq_ext still high -> interrupt entry taken from the next IDLE cycle.
//   T5 rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0, csr_op=NOP_OP throughout.
//   T6 reset_n=0 during ISSUE -> same cycle csr_op=NOP_OP, rsp_valid=0.
//      After release, state IDLE with req_ready=1.

Source files
------------

// File: rtl/csr_trap_sequencer.sv
// Sequences CSR instructions, exceptions, MRET and external-interrupt entry into the CSR unit.
// Accept in cycle 0, csr_op in cycle 1, response from cycle 3; the response is held until rsp_ready, and no new request is taken meanwhile.
module csr_trap_sequencer #(
  parameter logic [11:0] IRQ_CAUSE = 12'h01B,
  parameter logic [2:0]  NOP_OP    = 3'b010
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        rsp_is_irq,
  input  logic        irq_ext,
  input  logic [31:0] irq_pc,
  output logic [2:0]  csr_op,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  input  logic        csr_fault
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  localparam logic [2:0]  OP_EXC  = 3'b000;
  localparam logic [2:0]  OP_MRET = 3'b001;
  localparam logic [2:0]  OP_RW   = 3'b101;
  localparam logic [2:0]  OP_RS   = 3'b110;
  localparam logic [2:0]  OP_RC   = 3'b111;
  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;

  state_t state;
  logic   mie;
  logic   mpie;
  logic   meie;
  logic   is_irq;
  logic   irq_take;

  function automatic logic bit_update(input logic [2:0] op, input logic cur, input logic b);
    case (op)
      OP_RW:   return b;
      OP_RS:   return cur | b;
      OP_RC:   return cur & ~b;
      default: return cur;
    endcase
  endfunction

  assign irq_take  = irq_ext & mie & meie;
  assign req_ready = (state == IDLE) & ~irq_take;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_fault  <= 1'b0;
      rsp_is_irq <= 1'b0;
      csr_op     <= NOP_OP;
      csr_addr   <= '0;
      csr_wdata  <= '0;
      mie        <= 1'b0;
      mpie       <= 1'b0;
      meie       <= 1'b0;
      is_irq     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Interrupt wins; a concurrent core request simply stays pending.
          if (irq_take) begin
            csr_op    <= OP_EXC;
            csr_addr  <= IRQ_CAUSE;
            csr_wdata <= irq_pc;
            is_irq    <= 1'b1;
            state     <= ISSUE;
          end else if (req_valid) begin
            csr_op    <= req_op;
            csr_addr  <= req_addr;
            csr_wdata <= req_wdata;
            is_irq    <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          csr_op <= NOP_OP;
          state  <= CAPTURE;
          case (csr_op)
            OP_EXC: begin
              mpie <= mie;
              mie  <= 1'b0;
            end
            OP_MRET: mie <= mpie;
            OP_RW, OP_RS, OP_RC: begin
              if (csr_addr == ADDR_MSTATUS) begin
                mie  <= bit_update(csr_op, mie, csr_wdata[3]);
                mpie <= bit_update(csr_op, mpie, csr_wdata[7]);
              end else if (csr_addr == ADDR_MIE) begin
                meie <= bit_update(csr_op, meie, csr_wdata[11]);
              end
            end
            default: ;
          endcase
        end
        CAPTURE: begin
          rsp_rdata  <= csr_rdata;
          rsp_fault  <= csr_fault;
          rsp_is_irq <= is_irq;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed bench for csr_trap_sequencer with a behavioural CSR unit and a response scoreboard.
module tb_csr_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        rsp_is_irq;
  logic        irq_ext;
  logic [31:0] irq_pc;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata = '0;
  logic        csr_fault = 1'b0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
    logic        is_irq;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  csr_trap_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_fault  (rsp_fault),
    .rsp_is_irq (rsp_is_irq),
    .irq_ext    (irq_ext),
    .irq_pc     (irq_pc),
    .csr_op     (csr_op),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .csr_fault  (csr_fault)
  );

  // Behavioural CSR unit: registered read_value/fault, a handful of implemented CSRs.
  logic [31:0] m_status = '0, m_ie = '0, m_tvec = '0, m_epc = '0, m_cause = '0;
  always @(posedge clk) begin : csr_unit
    logic [31:0] old;
    logic [31:0] nv;
    logic        known;
    known = 1'b1;
    case (csr_addr)
      12'h300: old = m_status;
      12'h304: old = m_ie;
      12'h305: old = m_tvec;
      12'h341: old = m_epc;
      12'h342: old = m_cause;
      default: begin old = '0; known = 1'b0; end
    endcase
    nv = (csr_op == 3'b101) ? csr_wdata :
         (csr_op == 3'b110) ? (old | csr_wdata) : (old & ~csr_wdata);
    case (csr_op)
      3'b000: begin
        csr_rdata <= m_tvec; csr_fault <= 1'b0;
        m_epc <= csr_wdata; m_cause <= {20'd0, csr_addr};
      end
      3'b001: begin csr_rdata <= m_epc; csr_fault <= 1'b0; end
      3'b101, 3'b110, 3'b111: begin
        if (known) begin
          csr_rdata <= old; csr_fault <= 1'b0;
          case (csr_addr)
            12'h300: m_status <= nv;
            12'h304: m_ie     <= nv;
            12'h305: m_tvec   <= nv;
            12'h341: m_epc    <= nv;
            default: m_cause  <= nv;
          endcase
        end else begin
          csr_rdata <= '0; csr_fault <= 1'b1;
        end
      end
      default: begin csr_rdata <= '0; csr_fault <= 1'b1; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor: every handshake is matched against the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && rsp_valid && rsp_ready) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL rsp_unexpected: observed rdata %h is_irq %0b, expected no response", rsp_rdata, rsp_is_irq);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rsp_rdata",  rsp_rdata,        e.rdata);
        check("rsp_fault",  32'(rsp_fault),   32'(e.fault));
        check("rsp_is_irq", 32'(rsp_is_irq),  32'(e.is_irq));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] r, input logic f, input logic i);
    exp_t e;
    e.rdata = r; e.fault = f; e.is_irq = i;
    sb.push_back(e);
  endtask

  task automatic wait_accept();
    int   n;
    logic ok;
    n = 0; ok = 1'b0;
    while (!ok && n < 60) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      n++;
    end
    check("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                      input logic [31:0] er, input logic ef, input logic ei);
    push_exp(er, ef, ei);
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    wait_accept();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    tick();
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; irq_ext = 1'b0; irq_pc = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    check("rst_rsp_rdata",  rsp_rdata,       32'd0);
    check("rst_rsp_fault",  32'(rsp_fault),  32'd0);
    check("rst_rsp_is_irq", 32'(rsp_is_irq), 32'd0);
    check("rst_csr_op",     32'(csr_op),     32'd2);
    check("rst_csr_addr",   32'(csr_addr),   32'd0);
    check("rst_csr_wdata",  csr_wdata,       32'd0);
    tick();
    reset_n = 1'b1;

    // T1: latency of a single RW, then read back through RS
    tick();
    push_exp(32'd0, 1'b0, 1'b0);
    req_op = 3'b101; req_addr = 12'h305; req_wdata = 32'h1000; req_valid = 1'b1;
    @(negedge clk);
    check("t1_req_ready_c0", 32'(req_ready), 32'd1);
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    check("t1_csr_op_c1",    32'(csr_op),    32'd5);
    check("t1_csr_addr_c1",  32'(csr_addr),  32'h305);
    check("t1_csr_wdata_c1", csr_wdata,      32'h1000);
    check("t1_rsp_valid_c1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("t1_rsp_valid_c2", 32'(rsp_valid), 32'd0);
    check("t1_csr_op_c2",    32'(csr_op),    32'd2);
    @(negedge clk);
    check("t1_rsp_valid_c3", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    check("t1_req_ready_c4", 32'(req_ready), 32'd1);
    tick();
    send(3'b110, 12'h305, 32'd0, 32'h1000, 1'b0, 1'b0);
    wait_drain();

    // T2: unimplemented CSR and illegal op both fault and leave the shadows alone
    send(3'b101, 12'h7C0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    wait_drain();
    send(3'b011, 12'h300, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    wait_drain();
    irq_ext = 1'b1; irq_pc = 32'h55;
    repeat (3) begin
      @(negedge clk);
      check("t2_irq_masked", 32'(req_ready), 32'd1);
    end
    tick();
    irq_ext = 1'b0;

    // T3: enable interrupts, then interrupt beats a simultaneous request
    send(3'b110, 12'h300, 32'h8, 32'd0, 1'b0, 1'b0);
    wait_drain();
    send(3'b110, 12'h304, 32'h800, 32'd0, 1'b0, 1'b0);
    wait_drain();
    push_exp(32'h1000, 1'b0, 1'b1);
    push_exp(32'h1000, 1'b0, 1'b0);
    irq_ext = 1'b1; irq_pc = 32'h200;
    req_op = 3'b110; req_addr = 12'h305; req_wdata = 32'd0; req_valid = 1'b1;
    @(negedge clk);
    check("t3_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("t3_irq_op",    32'(csr_op),   32'd0);
    check("t3_irq_addr",  32'(csr_addr), 32'h01B);
    check("t3_irq_wdata", csr_wdata,     32'h200);
    wait_accept();
    wait_drain();
    repeat (4) begin
      @(negedge clk);
      check("t3_no_reentry", 32'(req_ready), 32'd1);
    end
    tick();

    // T4: MRET restores mie and the still-high irq re-enters right after
    send(3'b001, 12'h000, 32'd0, 32'h200, 1'b0, 1'b0);
    push_exp(32'h1000, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("t4_irq_blocks_req", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("t4_irq_op", 32'(csr_op), 32'd0);
    tick();
    irq_ext = 1'b0;
    wait_drain();

    // T5: response backpressure with another request waiting
    rsp_ready = 1'b0;
    send(3'b110, 12'h305, 32'd0, 32'h1000, 1'b0, 1'b0);
    push_exp(32'h1B, 1'b0, 1'b0);
    req_op = 3'b110; req_addr = 12'h342; req_wdata = 32'd0; req_valid = 1'b1;
    repeat (3) @(negedge clk);
    repeat (5) begin
      check("t5_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t5_rsp_rdata", rsp_rdata,      32'h1000);
      check("t5_rsp_fault", 32'(rsp_fault), 32'd0);
      check("t5_req_ready", 32'(req_ready), 32'd0);
      check("t5_csr_op",    32'(csr_op),    32'd2);
      @(negedge clk);
    end
    tick();
    rsp_ready = 1'b1;
    wait_accept();
    wait_drain();

    // T6: reset during ISSUE abandons the access
    req_op = 3'b101; req_addr = 12'h300; req_wdata = 32'h8; req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    check("t6_in_issue", 32'(csr_op), 32'd5);
    reset_n = 1'b0;
    #1;
    check("t6_rst_csr_op",    32'(csr_op),    32'd2);
    check("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("t6_req_ready", 32'(req_ready), 32'd1);
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    irq_ext = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t6_shadow_cleared", 32'(req_ready), 32'd1);
    end
    tick();
    irq_ext = 1'b0;
    repeat (3) tick();
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
